prbs_edge_slicer: RTL and testbench
===================================

PRBS_EDGE_SLICER -- requirements
Module: prbs_edge_slicer

Interface
REQ-001 Parameter TH_LO, default 16'h0CCD, low threshold (about 10% of 16'h7FFF full swing), unsigned.
REQ-002 Parameter TH_HI, default 16'h7333, high threshold (about 90%), unsigned; TH_HI > TH_LO SHALL hold.
REQ-003 dac_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 sample_in  in  16  unsigned shaped PRBS sample, 0x0000..0xFFFF.
REQ-006 sample_en  in  1  sample_in is valid this cycle; state SHALL NOT change when low.
REQ-007 edge_time_limit  in  8  maximum allowed edge time in samples; 0 disables the slow-edge check.
REQ-008 clear  in  1  single-cycle clear of runt_count and slow_edge_flag.
REQ-009 recovered_bit  out  1  hysteresis-sliced PRBS bit.
REQ-010 edge_valid  out  1  one-cycle pulse, edge measurement complete.
REQ-011 edge_dir  out  1  direction of the last completed edge: 1 rising, 0 falling.
REQ-012 edge_time  out  8  samples taken by the last completed edge.
REQ-013 runt_count  out  8  aborted-edge count, saturating at 255.
REQ-014 slow_edge_flag  out  1  sticky; set when a completed edge exceeded the limit.
REQ-015 edge_state_dbg  out  2  current FSM state encoding.

Function
REQ-016 FSM states SHALL be LOW=0, RISING=1, HIGH=2, FALLING=3.
REQ-017 All transitions SHALL occur only on cycles with sample_en=1. s denotes sample_in on that cycle.
REQ-018 LOW transitions:
- s >= TH_HI: go to HIGH and complete a rising edge with edge_time=1.
- TH_LO < s < TH_HI: go to RISING with the internal count set to 1.
- Otherwise stay in LOW.
REQ-019 RISING transitions:
- s >= TH_HI: count+1, go to HIGH, complete a rising edge.
- s <= TH_LO: go to LOW, increment runt_count, no edge_valid.
- Otherwise count+1.
REQ-020 HIGH and FALLING SHALL mirror REQ-018 and REQ-019 with the thresholds swapped and the comparisons inverted:
- s <= TH_LO from HIGH: go to LOW, edge_time=1.
- TH_LO < s < TH_HI from HIGH: go to FALLING.
- From FALLING, s >= TH_HI: runt, go back to HIGH.
REQ-021 The internal count SHALL saturate at 255; edge_time reports the saturated value.
REQ-022 On edge completion, on the following dac_clk edge:
- edge_valid=1 for exactly one cycle.
- edge_time and edge_dir are updated and then held until the next completion.
REQ-023 recovered_bit SHALL be 1 in HIGH and RISING and 0 in LOW and FALLING, registered with the state.
REQ-024 slow_edge_flag SHALL be set when edge_time_limit != 0 and the completed count > edge_time_limit; it SHALL clear only on clear or reset.
REQ-025 clear SHALL take priority over a same-cycle runt increment or flag set; it SHALL NOT affect the FSM, edge_valid, edge_time or edge_dir.
REQ-026 Back-to-back completions on consecutive enabled samples SHALL each produce their own edge_valid pulse.
REQ-027 edge_valid SHALL be 0 in any cycle following sample_en=0.

Reset
REQ-028 When reset_n=0 at a clock edge, the block SHALL enter LOW with these values:
- recovered_bit=0, edge_valid=0, edge_dir=0.
- edge_time=0, runt_count=0, slow_edge_flag=0.
- internal count=0, edge_state_dbg=0.
REQ-029 Reset mid-edge SHALL abandon the measurement with no edge_valid and no runt increment.

Verification
REQ-030 Ramp 0x0000, 0x2000, 0x4000, 0x6000, 0x7FFF with sample_en=1 -> edge_valid pulse with edge_dir=1, edge_time=4, recovered_bit=1.
REQ-031 Then step to 0x0000 -> edge_valid pulse with edge_dir=0, edge_time=1, state LOW.
REQ-032 Samples 0x0000, 0x4000, 0x0000 -> no edge_valid, runt_count=1, state LOW, recovered_bit=0.
REQ-033 edge_time_limit=3 with the REQ-030 ramp -> slow_edge_flag=1; then clear=1 for one cycle -> flag=0; limit=0 with the same ramp -> flag stays 0.
REQ-034 Hold at 0x4000 for 300 enabled samples, then 0x7FFF -> edge_time=255; a ramp interleaved with sample_en=0 cycles gives the same edge_time as REQ-030.
REQ-035 reset_n=0 during RISING -> all outputs at their reset values; the next 0x7FFF sample -> edge_time=1.

Source files
------------

// File: rtl/prbs_edge_slicer_if.sv
// prbs_edge_slicer_if: sample stream in, sliced bit and edge measurements out
interface prbs_edge_slicer_if;
  logic [15:0] sample_in;
  logic        sample_en;
  logic [7:0]  edge_time_limit;
  logic        clear;
  logic        recovered_bit;
  logic        edge_valid;
  logic        edge_dir;
  logic [7:0]  edge_time;
  logic [7:0]  runt_count;
  logic        slow_edge_flag;
  logic [1:0]  edge_state_dbg;
  modport master (
    output sample_in, sample_en, edge_time_limit, clear,
    input  recovered_bit, edge_valid, edge_dir, edge_time, runt_count, slow_edge_flag, edge_state_dbg
  );
  modport slave (
    input  sample_in, sample_en, edge_time_limit, clear,
    output recovered_bit, edge_valid, edge_dir, edge_time, runt_count, slow_edge_flag, edge_state_dbg
  );
endinterface

// File: rtl/prbs_edge_slicer.sv
// prbs_edge_slicer: hysteresis slicer measuring PRBS edge times and counting runt edges
module prbs_edge_slicer #(
  parameter logic [15:0] TH_LO = 16'h0CCD,
  parameter logic [15:0] TH_HI = 16'h7333
) (
  input logic              dac_clk,
  input logic              reset_n,
  prbs_edge_slicer_if.slave bus
);
  typedef enum logic [1:0] {LOW = 2'd0, RISING = 2'd1, HIGH = 2'd2, FALLING = 2'd3} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, edge_time_q, edge_time_d, runt_q, runt_d, cnt_inc;
  logic       edge_valid_q, edge_valid_d, edge_dir_q, edge_dir_d;
  logic       slow_q, slow_d, bit_q, bit_d;
  logic       hi, lo, done, runt;
  assign hi      = bus.sample_in >= TH_HI;
  assign lo      = bus.sample_in <= TH_LO;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_time_d = edge_time_q;
    edge_dir_d  = edge_dir_q;
    done        = 1'b0;
    runt        = 1'b0;
    if (bus.sample_en) begin
      case (state_q)
        LOW: begin
          state_d     = hi ? HIGH : lo ? LOW : RISING;
          cnt_d       = (!hi && !lo) ? 8'd1 : 8'd0;
          done        = hi;
          edge_dir_d  = hi ? 1'b1 : edge_dir_q;
          edge_time_d = hi ? 8'd1 : edge_time_q;
        end
        RISING: begin
          state_d     = hi ? HIGH : lo ? LOW : RISING;
          cnt_d       = (hi || lo) ? 8'd0 : cnt_inc;
          done        = hi;
          runt        = lo;
          edge_dir_d  = hi ? 1'b1 : edge_dir_q;
          edge_time_d = hi ? cnt_inc : edge_time_q;
        end
        HIGH: begin
          state_d     = lo ? LOW : hi ? HIGH : FALLING;
          cnt_d       = (!hi && !lo) ? 8'd1 : 8'd0;
          done        = lo;
          edge_dir_d  = lo ? 1'b0 : edge_dir_q;
          edge_time_d = lo ? 8'd1 : edge_time_q;
        end
        FALLING: begin
          state_d     = lo ? LOW : hi ? HIGH : FALLING;
          cnt_d       = (hi || lo) ? 8'd0 : cnt_inc;
          done        = lo;
          runt        = hi;
          edge_dir_d  = lo ? 1'b0 : edge_dir_q;
          edge_time_d = lo ? cnt_inc : edge_time_q;
        end
      endcase
    end
    edge_valid_d = done;
    bit_d        = (state_d == HIGH) || (state_d == RISING);
    // clear wins over a same-cycle runt increment or slow-edge set
    runt_d = bus.clear ? 8'd0 : (runt && runt_q != 8'hFF) ? runt_q + 8'd1 : runt_q;
    slow_d = bus.clear ? 1'b0 :
             slow_q | (done && bus.edge_time_limit != 8'd0 && edge_time_d > bus.edge_time_limit);
  end
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      state_q      <= LOW;
      cnt_q        <= 8'd0;
      edge_time_q  <= 8'd0;
      edge_dir_q   <= 1'b0;
      edge_valid_q <= 1'b0;
      runt_q       <= 8'd0;
      slow_q       <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_time_q  <= edge_time_d;
      edge_dir_q   <= edge_dir_d;
      edge_valid_q <= edge_valid_d;
      runt_q       <= runt_d;
      slow_q       <= slow_d;
      bit_q        <= bit_d;
    end
  end
  assign bus.recovered_bit  = bit_q;
  assign bus.edge_valid     = edge_valid_q;
  assign bus.edge_dir       = edge_dir_q;
  assign bus.edge_time      = edge_time_q;
  assign bus.runt_count     = runt_q;
  assign bus.slow_edge_flag = slow_q;
  assign bus.edge_state_dbg = state_q;
endmodule

// File: tb/tb_prbs_edge_slicer.sv
// tb_prbs_edge_slicer: directed and random checks of prbs_edge_slicer against a level/transit model
module tb_prbs_edge_slicer;
  localparam logic [15:0] TH_LO = 16'h0CCD;
  localparam logic [15:0] TH_HI = 16'h7333;
  logic dac_clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  // model: settled level, samples spent in the current transit (0 = settled)
  int m_l, m_n, m_ev, m_dir, m_et, m_runt, m_fl;
  prbs_edge_slicer_if bus ();
  prbs_edge_slicer #(.TH_LO(TH_LO), .TH_HI(TH_HI)) dut (.dac_clk(dac_clk), .reset_n(reset_n), .bus(bus));
  always #5 dac_clk = ~dac_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic model();
    int t;
    bit rn, st;
    rn = 0;
    st = 0;
    if (!reset_n) begin
      m_l = 0; m_n = 0; m_ev = 0; m_dir = 0; m_et = 0; m_runt = 0; m_fl = 0;
      return;
    end
    m_ev = 0;
    if (bus.sample_en) begin
      t = (bus.sample_in >= TH_HI) ? 1 : (bus.sample_in <= TH_LO) ? 0 : 2;
      if (t == 2) m_n = (m_n < 255) ? m_n + 1 : 255;
      else if (t != m_l) begin
        m_et = (m_n < 255) ? m_n + 1 : 255;
        m_dir = t; m_l = t; m_n = 0; m_ev = 1;
        st = (bus.edge_time_limit != 0) && (m_et > int'(bus.edge_time_limit));
      end else begin
        rn = (m_n > 0);
        m_n = 0;
      end
    end
    if (bus.clear) begin
      m_runt = 0; m_fl = 0;
    end else begin
      if (rn && m_runt < 255) m_runt++;
      if (st) m_fl = 1;
    end
  endtask
  task automatic cyc();
    @(posedge dac_clk);
    model();
    #1;
    chk("state", 32'(bus.edge_state_dbg), 32'(2 * m_l + (m_n > 0 ? 1 : 0)));
    chk("bit", 32'(bus.recovered_bit), 32'(m_l ^ (m_n > 0 ? 1 : 0)));
    chk("valid", 32'(bus.edge_valid), 32'(m_ev));
    chk("dir", 32'(bus.edge_dir), 32'(m_dir));
    chk("time", 32'(bus.edge_time), 32'(m_et));
    chk("runt", 32'(bus.runt_count), 32'(m_runt));
    chk("flag", 32'(bus.slow_edge_flag), 32'(m_fl));
  endtask
  task automatic smp(input logic [15:0] s, input logic en = 1'b1);
    bus.sample_in = s;
    bus.sample_en = en;
    cyc();
    bus.sample_en = 1'b0;
  endtask
  task automatic ramp();
    smp(16'h0000); smp(16'h2000); smp(16'h4000); smp(16'h6000); smp(16'h7FFF);
  endtask
  initial begin
    bus.sample_in = 16'h0; bus.sample_en = 1'b0; bus.edge_time_limit = 8'd0; bus.clear = 1'b0;
    cyc(); cyc();
    chk("rst_state", 32'(bus.edge_state_dbg), 32'd0);
    chk("rst_time", 32'(bus.edge_time), 32'd0);
    reset_n = 1'b1;
    cyc();
    ramp();
    chk("ramp_valid", 32'(bus.edge_valid), 32'd1);
    chk("ramp_dir", 32'(bus.edge_dir), 32'd1);
    chk("ramp_time", 32'(bus.edge_time), 32'd4);
    chk("ramp_bit", 32'(bus.recovered_bit), 32'd1);
    smp(16'h0000);
    chk("fall_valid", 32'(bus.edge_valid), 32'd1);
    chk("fall_dir", 32'(bus.edge_dir), 32'd0);
    chk("fall_time", 32'(bus.edge_time), 32'd1);
    chk("fall_state", 32'(bus.edge_state_dbg), 32'd0);
    smp(16'h0000); smp(16'h4000); smp(16'h0000);
    chk("runt_count", 32'(bus.runt_count), 32'd1);
    chk("runt_valid", 32'(bus.edge_valid), 32'd0);
    chk("runt_bit", 32'(bus.recovered_bit), 32'd0);
    smp(16'h0CCE); smp(16'h7333);
    chk("bnd_rise_time", 32'(bus.edge_time), 32'd2);
    smp(16'h7332); smp(16'h7333);
    chk("bnd_runt", 32'(bus.runt_count), 32'd2);
    smp(16'h0CCD);
    chk("bnd_fall", 32'(bus.edge_state_dbg), 32'd0);
    bus.edge_time_limit = 8'd3;
    ramp();
    chk("slow_set", 32'(bus.slow_edge_flag), 32'd1);
    smp(16'h0000);
    bus.clear = 1'b1;
    smp(16'h0000);
    bus.clear = 1'b0;
    chk("slow_clr", 32'(bus.slow_edge_flag), 32'd0);
    chk("runt_clr", 32'(bus.runt_count), 32'd0);
    bus.edge_time_limit = 8'd0;
    ramp();
    chk("slow_off", 32'(bus.slow_edge_flag), 32'd0);
    smp(16'h0000);
    for (int i = 0; i < 300; i++) smp(16'h4000);
    smp(16'h7FFF);
    chk("sat_time", 32'(bus.edge_time), 32'd255);
    smp(16'h0000);
    smp(16'h2000); smp(16'h0, 1'b0); smp(16'h4000); smp(16'h0, 1'b0); cyc();
    smp(16'h6000); smp(16'h0, 1'b0); smp(16'h7FFF);
    chk("gap_time", 32'(bus.edge_time), 32'd4);
    smp(16'h7FFF, 1'b0);
    chk("gap_valid", 32'(bus.edge_valid), 32'd0);
    smp(16'h0000); smp(16'h4000);
    reset_n = 1'b0;
    smp(16'h4000);
    chk("mid_rst_state", 32'(bus.edge_state_dbg), 32'd0);
    chk("mid_rst_runt", 32'(bus.runt_count), 32'd0);
    reset_n = 1'b1;
    smp(16'h7FFF);
    chk("post_rst_time", 32'(bus.edge_time), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [15:0] s;
      k = $urandom_range(0, 9);
      s = (k < 3) ? 16'($urandom_range(0, int'(TH_LO))) :
          (k < 6) ? 16'($urandom_range(int'(TH_HI), 16'hFFFF)) :
          (k == 6) ? TH_LO : (k == 7) ? TH_HI : 16'($urandom_range(int'(TH_LO) + 1, int'(TH_HI) - 1));
      bus.edge_time_limit = 8'($urandom_range(0, 6));
      bus.clear = ($urandom_range(0, 49) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      smp(s, $urandom_range(0, 3) != 0);
      bus.clear = 1'b0;
      reset_n = 1'b1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
